spi_slave_port: RTL and testbench

//  SPI slave endpoint, downstream of SPI_Master: consumes SCLK/MOSI/ss, returns MISO.

---
 rtl/spi_slave_port_pkg.sv | 23 ++
 rtl/spi_slave_port_pin_sync.sv | 32 +++
 rtl/spi_slave_port.sv | 167 ++++++++++++++++
 tb/tb_spi_slave_port.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_port_pkg.sv
// Shared definitions for the SPI slave port: mode encodings, CPOL/CPHA decode
// and the FSM state type.
package spi_slave_port_pkg;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  function automatic logic mode_cpol(input logic [1:0] mode);
    return mode[1];
  endfunction

  function automatic logic mode_cpha(input logic [1:0] mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/spi_slave_port_pin_sync.sv
// Two-flop synchroniser for an asynchronous pin, plus a third register that
// turns the synchronised level into single-cycle rise/fall pulses.
module spi_slave_port_pin_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
      s3_q <= RST_VAL;
    end else begin
      s1_q <= pin_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign sync_o = s2_q;
  assign rise_o = s2_q & ~s3_q;
  assign fall_o = ~s2_q & s3_q;

endmodule

// File: rtl/spi_slave_port.sv
// SPI slave endpoint: oversamples SCLK/MOSI/ss in the clk domain, deserialises
// MSB-first words into rx_data and serialises a preloaded tx word onto MISO.
//
// state     | meaning
// ST_IDLE   | ss deasserted, MISO held low, waiting for ss falling edge
// ST_ACTIVE | frame in progress, shifting on SCLK edges
module spi_slave_port
  import spi_slave_port_pkg::*;
#(
  parameter logic [1:0] MODE      = SPI_MODE0,
  parameter int         BITS_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 SCLK,
  input  logic                 MOSI,
  input  logic                 ss,
  output logic                 MISO,
  input  logic [BITS_SIZE-1:0] tx_data,
  input  logic                 tx_load,
  output logic                 tx_ready,
  output logic [BITS_SIZE-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 busy,
  output logic                 tx_underrun
);

  localparam logic CPOL = mode_cpol(MODE);
  localparam logic CPHA = mode_cpha(MODE);
  localparam int   CW   = $clog2(BITS_SIZE + 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic ss_s, ss_rise, ss_fall;
  logic mosi_s, unused_mosi_rise, unused_mosi_fall;

  spi_slave_port_pin_sync #(.RST_VAL(CPOL)) u_sync_sclk (
    .clk(clk), .reset(reset), .pin_i(SCLK),
    .sync_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  spi_slave_port_pin_sync #(.RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .reset(reset), .pin_i(ss),
    .sync_o(ss_s), .rise_o(ss_rise), .fall_o(ss_fall)
  );
  spi_slave_port_pin_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .pin_i(MOSI),
    .sync_o(mosi_s), .rise_o(unused_mosi_rise), .fall_o(unused_mosi_fall)
  );

  logic unused_sclk_level;
  assign unused_sclk_level = sclk_s;

  logic lead_e, trail_e, sample_e, shift_e;
  assign lead_e   = CPOL ? sclk_fall : sclk_rise;
  assign trail_e  = CPOL ? sclk_rise : sclk_fall;
  assign sample_e = CPHA ? trail_e : lead_e;
  assign shift_e  = CPHA ? lead_e  : trail_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [BITS_SIZE-1:0] tx_shift_q, tx_shift_d;
  logic [BITS_SIZE-1:0] rx_shift_q, rx_shift_d;
  logic [BITS_SIZE-1:0] rx_data_q, rx_data_d;
  logic [BITS_SIZE-1:0] hold_q, hold_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 under_q, under_d;
  logic                 miso_q, miso_d;
  logic                 reload;
  logic [BITS_SIZE-1:0] next_word;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    hold_d     = hold_q;
    tx_ready_d = tx_ready_q;
    rx_valid_d = 1'b0;
    under_d    = 1'b0;
    miso_d     = miso_q;
    reload     = 1'b0;
    next_word  = tx_ready_q ? '0 : hold_q;

    case (state_q)
      ST_IDLE: begin
        miso_d    = 1'b0;
        bit_cnt_d = '0;
        if (ss_fall) begin
          state_d = ST_ACTIVE;
          reload  = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (sample_e) begin
          rx_shift_d = {rx_shift_q[BITS_SIZE-2:0], mosi_s};
          if (bit_cnt_q == CW'(BITS_SIZE - 1)) begin
            rx_data_d  = {rx_shift_q[BITS_SIZE-2:0], mosi_s};
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
            reload     = ~ss_rise;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        if (shift_e) begin
          miso_d     = tx_shift_q[BITS_SIZE-1];
          tx_shift_d = {tx_shift_q[BITS_SIZE-2:0], 1'b0};
        end
        if (ss_rise) begin
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A reload always wins over a same-cycle tx_load; the load is dropped.
    if (reload) begin
      tx_ready_d = 1'b1;
      under_d    = tx_ready_q;
      if (state_q == ST_IDLE && !CPHA) begin
        miso_d     = next_word[BITS_SIZE-1];
        tx_shift_d = {next_word[BITS_SIZE-2:0], 1'b0};
      end else begin
        tx_shift_d = next_word;
      end
    end else if (tx_load && tx_ready_q) begin
      hold_d     = tx_data;
      tx_ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      hold_q     <= '0;
      tx_ready_q <= 1'b1;
      rx_valid_q <= 1'b0;
      under_q    <= 1'b0;
      miso_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      hold_q     <= hold_d;
      tx_ready_q <= tx_ready_d;
      rx_valid_q <= rx_valid_d;
      under_q    <= under_d;
      miso_q     <= miso_d;
    end
  end

  assign MISO        = miso_q;
  assign tx_ready    = tx_ready_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = under_q;
  assign busy        = (state_q == ST_ACTIVE) && !ss_s;

endmodule

// File: tb/tb_spi_slave_port.sv
// Bench for spi_slave_port: one instance per SPI mode driven by a behavioural
// SPI master; vector table, hand-written corner sequences and random bursts.
module tb_spi_slave_port;

  localparam int H = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      sclk, mosi, ss, tx_load;
  logic [3:0]      miso, tx_ready, rx_valid, busy, und;
  logic [7:0]      tx_data;
  logic [3:0][7:0] rx_data;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_port #(.MODE(2'(g)), .BITS_SIZE(8)) u_dut (
      .clk(clk), .reset(reset), .SCLK(sclk[g]), .MOSI(mosi[g]), .ss(ss[g]),
      .MISO(miso[g]), .tx_data(tx_data), .tx_load(tx_load[g]),
      .tx_ready(tx_ready[g]), .rx_data(rx_data[g]), .rx_valid(rx_valid[g]),
      .busy(busy[g]), .tx_underrun(und[g])
    );
  end

  int checks = 0;
  int errors = 0;

  logic [7:0] rxq[$];
  int         und_cnt;
  int         und_first;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rx_valid[i]) begin
        if (rxq.size() == 0) und_first = und_cnt;
        rxq.push_back(rx_data[i]);
      end
    end
    if (|und) und_cnt++;
  end

  logic [7:0] mw[4], tw[4], gw[4];
  bit         le[4];
  int         nwords, nbits, rst_w, rst_b;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input int m, input logic [7:0] d);
    tx_data    = d;
    tx_load[m] = 1'b1;
    tick(1);
    tx_load[m] = 1'b0;
  endtask

  // Behavioural master: nwords words of nbits each, MSB first, ss held low.
  task automatic xfer(input int m);
    logic [1:0] md;
    logic       cpol, cpha;
    md   = 2'(m);
    cpol = md[1];
    cpha = md[0];
    for (int w = 0; w < 4; w++) gw[w] = 8'h00;
    if (le[0]) load(m, tw[0]);
    ss[m] = 1'b0;
    tick(H);
    for (int w = 0; w < nwords; w++) begin
      for (int b = 7; b >= 8 - nbits; b--) begin
        if (w == rst_w && b == rst_b) begin
          reset = 1'b1;
          tick(1);
          reset = 1'b0;
          chk("rst_miso", 32'(miso[m]), 0);
          chk("rst_tx_ready", 32'(tx_ready[m]), 1);
          chk("rst_rx_data", 32'(rx_data[m]), 0);
          chk("rst_rx_valid", 32'(rx_valid[m]), 0);
          chk("rst_busy", 32'(busy[m]), 0);
          chk("rst_underrun", 32'(und[m]), 0);
        end
        if (b == 5 && w + 1 < nwords && le[w+1]) load(m, tw[w+1]);
        if (!cpha) begin
          mosi[m] = mw[w][b];
          tick(H);
          sclk[m] = ~cpol;
          gw[w][b] = miso[m];
          tick(H);
          sclk[m] = cpol;
        end else begin
          sclk[m] = ~cpol;
          mosi[m] = mw[w][b];
          tick(H);
          sclk[m] = cpol;
          gw[w][b] = miso[m];
          tick(H);
        end
      end
    end
    tick(H);
    ss[m]   = 1'b1;
    mosi[m] = 1'b0;
    tick(2 * H);
  endtask

  task automatic run_single(input int m, input logic [7:0] tx, input logic [7:0] mo, input bit do_load);
    rxq.delete();
    und_cnt   = 0;
    und_first = -1;
    nwords    = 1;
    nbits     = 8;
    mw[0]     = mo;
    tw[0]     = tx;
    le[0]     = do_load;
    xfer(m);
  endtask

  typedef struct {
    int         mode;
    logic [7:0] tx;
    logic [7:0] mo;
    logic [7:0] exp_rx;
    logic [7:0] exp_master;
  } vec_t;

  vec_t tbl[6];

  initial begin
    reset = 1'b1; sclk = 4'b1100; mosi = '0; ss = '1; tx_load = '0; tx_data = '0;
    rst_w = -1; rst_b = -1;
    tick(3);
    reset = 1'b0;
    tick(1);
    chk("reset_miso", 32'(miso), 0);
    chk("reset_tx_ready", 32'(tx_ready), 32'hF);
    chk("reset_rx_valid", 32'(rx_valid), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_underrun", 32'(und), 0);
    chk("reset_rx_data", 32'(rx_data), 0);

    tbl[0] = '{0, 8'h3C, 8'hA5, 8'hA5, 8'h3C};
    tbl[1] = '{1, 8'h7E, 8'h81, 8'h81, 8'h7E};
    tbl[2] = '{2, 8'h7E, 8'h81, 8'h81, 8'h7E};
    tbl[3] = '{3, 8'h7E, 8'h81, 8'h81, 8'h7E};
    tbl[4] = '{1, 8'h81, 8'h7E, 8'h7E, 8'h81};
    tbl[5] = '{3, 8'hC9, 8'h36, 8'h36, 8'hC9};
    for (int i = 0; i < 6; i++) begin
      run_single(tbl[i].mode, tbl[i].tx, tbl[i].mo, 1'b1);
      chk("vec_rx_count", rxq.size(), 1);
      if (rxq.size() > 0) chk("vec_rx_word", 32'(rxq[0]), 32'(tbl[i].exp_rx));
      chk("vec_master_rx", 32'(gw[0]), 32'(tbl[i].exp_master));
      chk("vec_rx_data_hold", 32'(rx_data[tbl[i].mode]), 32'(tbl[i].exp_rx));
      chk("vec_underrun_at_start", und_first, 0);
      chk("vec_miso_idle", 32'(miso), 0);
      chk("vec_busy_idle", 32'(busy), 0);
    end

    // Underrun: nothing loaded before the frame.
    run_single(0, 8'h00, 8'hFF, 1'b0);
    chk("under_master_rx", 32'(gw[0]), 0);
    if (rxq.size() > 0) chk("under_rx_word", 32'(rxq[0]), 32'hFF);
    chk("under_rx_count", rxq.size(), 1);
    chk("under_pulse_count", und_first, 1);

    // Aborted frame after 4 bits, then a full one.
    rxq.delete();
    nwords = 1; nbits = 4; mw[0] = 8'h5A; tw[0] = 8'h55; le[0] = 1'b1;
    xfer(0);
    chk("abort_no_valid", rxq.size(), 0);
    chk("abort_rx_data_kept", 32'(rx_data[0]), 32'hFF);
    chk("abort_tx_ready", 32'(tx_ready[0]), 1);
    run_single(0, 8'hC3, 8'h5A, 1'b1);
    chk("after_abort_rx", rxq.size() > 0 ? 32'(rxq[0]) : 32'hDEAD, 32'h5A);
    chk("after_abort_master", 32'(gw[0]), 32'hC3);

    // Second load while the holding register is full is ignored.
    load(1, 8'hA1);
    chk("full_tx_ready", 32'(tx_ready[1]), 0);
    load(1, 8'hB2);
    run_single(1, 8'h00, 8'h42, 1'b0);
    chk("reject_master_rx", 32'(gw[0]), 32'hA1);
    chk("reject_rx", rxq.size() > 0 ? 32'(rxq[0]) : 32'hDEAD, 32'h42);

    // Two-word bursts with the second tx word loaded during the first.
    for (int m = 0; m < 4; m += 3) begin
      rxq.delete();
      nwords = 2; nbits = 8;
      mw[0] = 8'h33; mw[1] = 8'hCC; tw[0] = 8'h11; tw[1] = 8'h22; le[0] = 1'b1; le[1] = 1'b1;
      xfer(m);
      chk("burst_rx_count", rxq.size(), 2);
      if (rxq.size() == 2) begin
        chk("burst_rx0", 32'(rxq[0]), 32'h33);
        chk("burst_rx1", 32'(rxq[1]), 32'hCC);
      end
      chk("burst_master0", 32'(gw[0]), 32'h11);
      chk("burst_master1", 32'(gw[1]), 32'h22);
    end

    // Reset pulse at bit 3 of a frame.
    rxq.delete();
    nwords = 1; nbits = 8; mw[0] = 8'h96; tw[0] = 8'h69; le[0] = 1'b1;
    rst_w = 0; rst_b = 4;
    xfer(0);
    rst_w = -1; rst_b = -1;
    chk("rst_master_tail_zero", 32'(gw[0][4:0]), 0);
    chk("rst_no_valid", rxq.size(), 0);
    run_single(0, 8'hE7, 8'h18, 1'b1);
    chk("post_rst_rx", rxq.size() > 0 ? 32'(rxq[0]) : 32'hDEAD, 32'h18);
    chk("post_rst_master", 32'(gw[0]), 32'hE7);

    // Random bursts: every MOSI word must arrive; master gets the loaded word or 0.
    for (int it = 0; it < 16; it++) begin
      int m;
      m = int'($urandom_range(0, 3));
      nwords = int'($urandom_range(1, 3));
      nbits = 8;
      for (int w = 0; w < 4; w++) begin
        mw[w] = 8'($urandom);
        tw[w] = 8'($urandom);
        le[w] = ($urandom_range(0, 3) != 0);
      end
      rxq.delete();
      xfer(m);
      chk("rand_rx_count", rxq.size(), nwords);
      for (int w = 0; w < nwords; w++) begin
        if (w < rxq.size()) chk("rand_rx_word", 32'(rxq[w]), 32'(mw[w]));
        chk("rand_master_word", 32'(gw[w]), le[w] ? 32'(tw[w]) : 32'h0);
      end
      chk("rand_miso_idle", 32'(miso), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
